// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared state encodings and defaults for the fetch sequencer.
// Revision    : 1.0
// ============================================================================
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_ST_WAIT   = 2'd0,
        FETCH_ST_RUN    = 2'd1,
        FETCH_ST_BUBBLE = 2'd2
    } fetch_state_t;

    localparam int unsigned WAIT_CLK_COUNT = 4;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational branch/jump target; branch has priority over jump.
// Revision    : 1.0
// ============================================================================
module next_pc_calc (
    input  logic [31:0] i_dec_pc4,
    input  logic [31:0] i_offset,
    input  logic        i_branch,
    input  logic        i_jmp,
    output logic [31:0] o_target
);

    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;

    assign w_branch_tgt = i_dec_pc4 + {i_offset[29:0], 2'b00};
    assign w_jump_tgt   = {i_dec_pc4[31:28], i_offset[25:0], 2'b00};

    always_comb begin
        o_target = i_dec_pc4;
        if (i_branch) begin
            o_target = w_branch_tgt;
        end else if (i_jmp) begin
            o_target = w_jump_tgt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : PC sequencer: start-up wait, valid/ready fetch, stall, redirect.
// Revision    : 1.0
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = WAIT_CLK_COUNT,
    parameter bit          DELAY_SLOT  = 1'b0
) (
    input  logic        fetch_ctrl_clk,
    input  logic        fetch_ctrl_rst,
    input  logic        fetch_ctrl_stall,
    input  logic        fetch_ctrl_branch,
    input  logic        fetch_ctrl_jmp,
    input  logic [31:0] fetch_ctrl_offset_addr,
    input  logic        fetch_ctrl_imem_ready,
    output logic [31:0] fetch_ctrl_pc_out,
    output logic        fetch_ctrl_pc_valid,
    output logic        fetch_ctrl_flush,
    output logic [31:0] fetch_ctrl_fetch_count
);

    localparam logic [31:0] c_WAIT_LAST = 32'(WAIT_CYCLES - 1);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_dec_pc4;
    logic [31:0]  r_wait_cnt;
    logic [31:0]  r_fetch_count;
    logic         r_pc_valid;
    logic         r_flush;

    logic [31:0]  w_target;
    logic         w_accept;
    logic         w_redirect;

    assign w_accept   = r_pc_valid & fetch_ctrl_imem_ready & ~fetch_ctrl_stall;
    assign w_redirect = fetch_ctrl_branch | fetch_ctrl_jmp;

    next_pc_calc u_next_pc_calc (
        .i_dec_pc4 (r_dec_pc4),
        .i_offset  (fetch_ctrl_offset_addr),
        .i_branch  (fetch_ctrl_branch),
        .i_jmp     (fetch_ctrl_jmp),
        .o_target  (w_target)
    );

    always_ff @(posedge fetch_ctrl_clk) begin
        if (fetch_ctrl_rst) begin
            r_state       <= (WAIT_CYCLES > 0) ? FETCH_ST_WAIT : FETCH_ST_RUN;
            r_pc          <= RESET_PC;
            r_dec_pc4     <= pc_plus4(RESET_PC);
            r_wait_cnt    <= 32'd0;
            r_fetch_count <= 32'd0;
            r_pc_valid    <= 1'b0;
            r_flush       <= 1'b0;
        end else begin
            case (r_state)
                FETCH_ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 32'd1;
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state    <= FETCH_ST_RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                FETCH_ST_RUN: begin
                    if (w_accept) begin
                        r_dec_pc4     <= pc_plus4(r_pc);
                        r_fetch_count <= r_fetch_count + 32'd1;
                    end
                    // A redirect overrides both the stall hold and the sequential step.
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (DELAY_SLOT) begin
                            r_pc_valid <= 1'b1;
                            r_flush    <= 1'b0;
                        end else begin
                            r_state    <= FETCH_ST_BUBBLE;
                            r_pc_valid <= 1'b0;
                            r_flush    <= 1'b1;
                        end
                    end else begin
                        if (w_accept) begin
                            r_pc <= pc_plus4(r_pc);
                        end
                        r_pc_valid <= 1'b1;
                        r_flush    <= 1'b0;
                    end
                end
                FETCH_ST_BUBBLE: begin
                    r_state    <= FETCH_ST_RUN;
                    r_pc_valid <= 1'b1;
                    r_flush    <= 1'b0;
                end
                default: begin
                    r_state    <= FETCH_ST_RUN;
                    r_pc_valid <= 1'b0;
                    r_flush    <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_ctrl_pc_out      = r_pc;
    assign fetch_ctrl_pc_valid    = r_pc_valid;
    assign fetch_ctrl_flush       = r_flush;
    assign fetch_ctrl_fetch_count = r_fetch_count;

endmodule
`default_nettype wire
